ka_16bit: RTL and testbench

- Pipelined 16x16 unsigned multiplier built on the Karatsuba decomposition. It returns the full 32-bit product.
- It is the top of a recursive structure: 16-bit level → 8-bit Karatsuba → 4-bit Karatsuba → 2-bit schoolbook leaf.
- It is used as a datapath arithmetic block and accepts one operand pair per clock.

---
 rtl/ka_16bit_if.sv | 12 +
 rtl/ka_16bit.sv | 100 ++++++++++
 tb/tb_ka_16bit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ka_16bit_if.sv
// Operand/product bus for the ka_16bit multiplier: one operand pair in, one product out.
// There is no backpressure: the consumer must take y in the cycle out_valid is high.
interface ka_16bit_if;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [31:0] y;

    modport master (output in_valid, a, b, input out_valid, y);
    modport slave  (input in_valid, a, b, output out_valid, y);
endinterface

// File: rtl/ka_16bit.sv
// Two-stage 16x16 unsigned Karatsuba multiplier with a full 32-bit product.
// Recursion: 16 -> 8 -> 4 -> 2-bit schoolbook leaf, one operand pair per clock.
module ka_16bit (
    input  logic   clk,
    input  logic   rst_n,
    ka_16bit_if.slave bus
);

    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] w);
        mul2 = ({2'b00, x} & {4{w[0]}}) + ({1'b0, x, 1'b0} & {4{w[1]}});
    endfunction

    // 3-bit half-sums are multiplied as 2x2 plus the carry-bit cross terms.
    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] w);
        logic [3:0] z2, z0;
        logic [2:0] sx, sw;
        logic [5:0] zm, z1;
        z2 = mul2(x[3:2], w[3:2]);
        z0 = mul2(x[1:0], w[1:0]);
        sx = {1'b0, x[3:2]} + {1'b0, x[1:0]};
        sw = {1'b0, w[3:2]} + {1'b0, w[1:0]};
        zm = {2'b00, mul2(sx[1:0], sw[1:0])}
           + (sx[2] ? {2'b00, sw[1:0], 2'b00} : 6'd0)
           + (sw[2] ? {2'b00, sx[1:0], 2'b00} : 6'd0)
           + ((sx[2] & sw[2]) ? 6'd16 : 6'd0);
        z1 = zm - {2'b00, z2} - {2'b00, z0};
        mul4 = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
    endfunction

    function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] w);
        logic [7:0] z2, z0;
        logic [4:0] sx, sw;
        logic [9:0] zm, z1;
        z2 = mul4(x[7:4], w[7:4]);
        z0 = mul4(x[3:0], w[3:0]);
        sx = {1'b0, x[7:4]} + {1'b0, x[3:0]};
        sw = {1'b0, w[7:4]} + {1'b0, w[3:0]};
        zm = {2'b00, mul4(sx[3:0], sw[3:0])}
           + (sx[4] ? {2'b00, sw[3:0], 4'b0000} : 10'd0)
           + (sw[4] ? {2'b00, sx[3:0], 4'b0000} : 10'd0)
           + ((sx[4] & sw[4]) ? 10'd256 : 10'd0);
        z1 = zm - {2'b00, z2} - {2'b00, z0};
        mul8 = {z2, 8'h00} + {2'b00, z1, 4'b0000} + {8'h00, z0};
    endfunction

    function automatic logic [17:0] mul9(input logic [8:0] x, input logic [8:0] w);
        mul9 = {2'b00, mul8(x[7:0], w[7:0])}
             + (x[8] ? {2'b00, w[7:0], 8'h00} : 18'd0)
             + (w[8] ? {2'b00, x[7:0], 8'h00} : 18'd0)
             + ((x[8] & w[8]) ? 18'h10000 : 18'd0);
    endfunction

    logic [15:0] z2_p1_d, z2_p1_q;
    logic [15:0] z0_p1_d, z0_p1_q;
    logic [17:0] zm_p1_d, zm_p1_q;
    logic        vld_p1_d, vld_p1_q;
    logic [31:0] y_p2_d, y_p2_q;
    logic        vld_p2_d, vld_p2_q;
    logic [8:0]  sa, sb;
    logic [17:0] z1;

    // Stage 1: partial products z2, z0 and the 9x9 middle product.
    always_comb begin
        sa       = {1'b0, bus.a[15:8]} + {1'b0, bus.a[7:0]};
        sb       = {1'b0, bus.b[15:8]} + {1'b0, bus.b[7:0]};
        z2_p1_d  = mul8(bus.a[15:8], bus.b[15:8]);
        z0_p1_d  = mul8(bus.a[7:0], bus.b[7:0]);
        zm_p1_d  = mul9(sa, sb);
        vld_p1_d = bus.in_valid;
    end

    // Stage 2: recombine; z1 is never negative and fits in 17 bits.
    always_comb begin
        z1       = zm_p1_q - {2'b00, z2_p1_q} - {2'b00, z0_p1_q};
        y_p2_d   = {z2_p1_q, 16'h0000} + {6'b000000, z1, 8'h00} + {16'h0000, z0_p1_q};
        vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z2_p1_q  <= '0;
            z0_p1_q  <= '0;
            zm_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            y_p2_q   <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            z2_p1_q  <= z2_p1_d;
            z0_p1_q  <= z0_p1_d;
            zm_p1_q  <= zm_p1_d;
            vld_p1_q <= vld_p1_d;
            y_p2_q   <= y_p2_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    assign bus.y         = y_p2_q;
    assign bus.out_valid = vld_p2_q;

endmodule

// File: tb/tb_ka_16bit.sv
// Scoreboard bench for ka_16bit: stimulus pushes expected products with their due cycle,
// a negedge monitor pops and checks value and latency whenever out_valid is seen.
module tb_ka_16bit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [31:0] y;
        int          due;
    } exp_t;
    exp_t sb[$];

    ka_16bit_if bus ();

    ka_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        if (v) begin
            e.y   = exp;
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 16'h0000, 16'h0000, 32'h0);
    endtask

    // Monitor: checks every out_valid against the queue and flags late/missing results.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_out: no out_valid for 0x%08h due cycle %0d (now %0d)",
                         sb[0].y, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: out_valid with y=0x%08h, none expected (cycle %0d)",
                             bus.y, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("product", bus.y, e.y);
                end
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rv;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("reset_y", bus.y, 32'h0);
        chk("reset_vld", {31'b0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        issue(1'b1, 16'hABAB, 16'hDEDE, 32'h9573284A);
        idle(4);

        issue(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        issue(1'b1, 16'h0000, 16'h1234, 32'h00000000);
        issue(1'b1, 16'h0001, 16'hBEEF, 32'h0000BEEF);
        issue(1'b1, 16'h8000, 16'h8000, 32'h40000000);
        issue(1'b1, 16'hFFFF, 16'h0001, 32'h0000FFFF);
        issue(1'b1, 16'h00FF, 16'h00FF, 32'h0000FE01);
        idle(4);

        // Reset asserted one cycle after issue: the in-flight product must vanish.
        issue(1'b1, 16'h1234, 16'h5678, 32'h06260060);
        idle(1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_y", bus.y, 32'h0);
        chk("midrst_vld", {31'b0, bus.out_valid}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        issue(1'b1, 16'h0003, 16'h0005, 32'h0000000F);
        idle(4);

        issue(1'b1, 16'h0002, 16'h0003, 32'h00000006);
        issue(1'b0, 16'h5555, 16'h5555, 32'h0);
        issue(1'b1, 16'hFF00, 16'h00FF, 32'h00FE0100);
        idle(4);

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rv = 1'($urandom_range(0, 1));
            issue(rv, ra, rb, 32'(ra) * 32'(rb));
        end
        idle(5);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
